// File: rtl/chebyshev_coeff_feeder.sv
// Source-side sequencer for chebyshev_computation_v2. It keeps a programmable
// coefficient bank and accepts one sample per transaction. For each sample it
// streams one (sample, coefficient) pair per cycle, then waits out the
// computation pipeline. It captures data_out and offers it on a valid/ready port.
module chebyshev_coeff_feeder #(
  parameter int WL       = 4,
  parameter int CL       = 4,
  parameter int WIDENING = 1,
  parameter int N_COEFF  = 4,
  parameter int LATENCY  = 3,
  localparam int OUT     = 2*WL+CL+WIDENING,
  localparam int AW      = $clog2(N_COEFF)
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [CL-1:0]  cfg_coeff,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic [WL-1:0]  x_data,
  output logic [WL-1:0]  data_in,
  output logic [CL-1:0]  coeff_in,
  input  logic [OUT-1:0] data_out,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [OUT-1:0] y_data,
  output logic           busy
);

  localparam int DW = $clog2(LATENCY+1);
  localparam logic [AW-1:0] K_LAST     = AW'(N_COEFF-1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(LATENCY);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, HOLD} state_e;

  state_e         stateQ, stateD;
  logic [AW-1:0]  kQ, kD;
  logic [DW-1:0]  drainQ, drainD;
  logic [WL-1:0]  xRegQ, xRegD;
  logic [WL-1:0]  dataInQ, dataInD;
  logic [CL-1:0]  coeffInQ, coeffInD;
  logic [OUT-1:0] yDataQ, yDataD;
  logic           yValidQ, yValidD;
  logic           busyQ, busyD;
  logic [CL-1:0]  bankQ [N_COEFF];
  logic           bankWe;

  // Samples are only taken while idle; x_ready therefore reads 1 during reset too.
  assign x_ready  = (stateQ == IDLE);

  // Configuration is frozen while a transaction is in flight and out-of-range
  // indices are dropped; an accept-cycle write lands before the first bank read.
  assign bankWe   = cfg_we && (stateQ == IDLE) && (int'(cfg_addr) < N_COEFF);

  assign data_in  = dataInQ;
  assign coeff_in = coeffInQ;
  assign y_data   = yDataQ;
  assign y_valid  = yValidQ;
  assign busy     = busyQ;

  // Coefficient bank: cleared by reset, written only from IDLE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_COEFF; i++) begin
        bankQ[i] <= '0;
      end
    end else if (bankWe) begin
      bankQ[cfg_addr] <= cfg_coeff;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stateQ   <= IDLE;
      kQ       <= '0;
      drainQ   <= '0;
      xRegQ    <= '0;
      dataInQ  <= '0;
      coeffInQ <= '0;
      yDataQ   <= '0;
      yValidQ  <= 1'b0;
      busyQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      kQ       <= kD;
      drainQ   <= drainD;
      xRegQ    <= xRegD;
      dataInQ  <= dataInD;
      coeffInQ <= coeffInD;
      yDataQ   <= yDataD;
      yValidQ  <= yValidD;
      busyQ    <= busyD;
    end
  end

  // Next-state logic: the drain capture fires on the edge where the counter hits 0.
  always_comb begin
    stateD   = stateQ;
    kD       = kQ;
    drainD   = drainQ;
    xRegD    = xRegQ;
    dataInD  = '0;
    coeffInD = '0;
    yDataD   = yDataQ;
    unique case (stateQ)
      IDLE: begin
        if (x_valid) begin
          xRegD  = x_data;
          kD     = '0;
          stateD = STREAM;
        end
      end
      STREAM: begin
        dataInD  = xRegQ;
        coeffInD = bankQ[kQ];
        if (kQ == K_LAST) begin
          drainD = DRAIN_LOAD;
          stateD = DRAIN;
        end else begin
          kD = kQ + AW'(1);
        end
      end
      DRAIN: begin
        drainD = drainQ - DW'(1);
        if (drainQ == DRAIN_LAST) begin
          yDataD = data_out;
          stateD = HOLD;
        end
      end
      HOLD: begin
        if (y_ready) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
    yValidD = (stateD == HOLD);
    busyD   = (stateD != IDLE);
  end

endmodule

// File: tb/tb_chebyshev_coeff_feeder.sv
// Randomized self-checking bench for chebyshev_coeff_feeder. It keeps a
// reference coefficient bank and the expected pair list and result per
// transaction. It also plays the computation block by driving the real result
// only on the capture edge and garbage on every other edge.
module tb_chebyshev_coeff_feeder;

  localparam int WL       = 4;
  localparam int CL       = 4;
  localparam int WIDENING = 1;
  localparam int N_COEFF  = 4;
  localparam int LATENCY  = 3;
  localparam int OUT      = 2*WL+CL+WIDENING;
  localparam int AW       = $clog2(N_COEFF);

  logic           clock;
  logic           resetn;
  logic           cfg_we;
  logic [AW-1:0]  cfg_addr;
  logic [CL-1:0]  cfg_coeff;
  logic           x_valid;
  logic           x_ready;
  logic [WL-1:0]  x_data;
  logic [WL-1:0]  data_in;
  logic [CL-1:0]  coeff_in;
  logic [OUT-1:0] data_out;
  logic           y_valid;
  logic           y_ready;
  logic [OUT-1:0] y_data;
  logic           busy;

  int checks = 0;
  int errors = 0;
  logic [CL-1:0] bankModel [N_COEFF];

  chebyshev_coeff_feeder #(
    .WL(WL), .CL(CL), .WIDENING(WIDENING), .N_COEFF(N_COEFF), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .resetn(resetn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coeff(cfg_coeff),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .data_in(data_in), .coeff_in(coeff_in), .data_out(data_out),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .busy(busy)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A data_out value guaranteed to differ from the real result.
  function automatic logic [OUT-1:0] garbage(input logic [OUT-1:0] r);
    logic [OUT-1:0] m;
    m = OUT'($urandom_range(1, (1 << OUT) - 1));
    return r ^ m;
  endfunction

  // Idle-time coefficient write; the model bank follows.
  task automatic writeCoeff(input int addr, input logic [CL-1:0] val);
    cfg_we    = 1'b1;
    cfg_addr  = addr[AW-1:0];
    cfg_coeff = val;
    @(posedge clock);
    #1;
    cfg_we = 1'b0;
    bankModel[addr] = val;
  endtask

  // One full transaction: accept, stream, drain, capture, optional stall, release.
  task automatic applyStimulus(input logic [WL-1:0] x, input logic [OUT-1:0] res, input int stall,
                               input bit busyWrite, input bit acceptWrite,
                               input int awAddr, input logic [CL-1:0] awVal);
    logic [CL-1:0] expC [N_COEFF];
    @(negedge clock);
    checkOutput("idle x_ready", 32'(x_ready), 32'd1);
    x_valid  = 1'b1;
    x_data   = x;
    y_ready  = 1'b0;
    data_out = garbage(res);
    if (acceptWrite) begin
      cfg_we    = 1'b1;
      cfg_addr  = awAddr[AW-1:0];
      cfg_coeff = awVal;
      bankModel[awAddr] = awVal;
    end
    for (int i = 0; i < N_COEFF; i++) expC[i] = bankModel[i];
    @(posedge clock);
    #1;
    x_valid = 1'b0;
    cfg_we  = 1'b0;
    for (int c = 1; c <= N_COEFF + LATENCY; c++) begin
      data_out = (c == N_COEFF + LATENCY) ? res : garbage(res);
      if (busyWrite && c == 2) begin
        cfg_we    = 1'b1;
        cfg_addr  = AW'(1);
        cfg_coeff = 4'b0111;
      end
      @(posedge clock);
      #1;
      cfg_we = 1'b0;
      @(negedge clock);
      if (c <= N_COEFF) begin
        checkOutput($sformatf("data_in c%0d", c), 32'(data_in), 32'(x));
        checkOutput($sformatf("coeff_in c%0d", c), 32'(coeff_in), 32'(expC[c-1]));
      end else begin
        checkOutput($sformatf("data_in drain c%0d", c), 32'(data_in), 32'd0);
        checkOutput($sformatf("coeff_in drain c%0d", c), 32'(coeff_in), 32'd0);
      end
      checkOutput($sformatf("y_valid c%0d", c), 32'(y_valid), (c == N_COEFF + LATENCY) ? 32'd1 : 32'd0);
      checkOutput($sformatf("busy c%0d", c), 32'(busy), 32'd1);
      checkOutput($sformatf("x_ready c%0d", c), 32'(x_ready), 32'd0);
    end
    checkOutput("y_data capture", 32'(y_data), 32'(res));
    for (int s = 0; s < stall; s++) begin
      data_out = garbage(res);
      x_valid  = 1'b1;
      x_data   = ~x;
      @(posedge clock);
      @(negedge clock);
      checkOutput("stall y_valid", 32'(y_valid), 32'd1);
      checkOutput("stall y_data", 32'(y_data), 32'(res));
      checkOutput("stall x_ready", 32'(x_ready), 32'd0);
      checkOutput("stall busy", 32'(busy), 32'd1);
    end
    x_valid  = 1'b0;
    y_ready  = 1'b1;
    data_out = garbage(res);
    @(posedge clock);
    @(negedge clock);
    checkOutput("release y_valid", 32'(y_valid), 32'd0);
    checkOutput("release x_ready", 32'(x_ready), 32'd1);
    checkOutput("release busy", 32'(busy), 32'd0);
    y_ready = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_coeff = '0;
    x_valid   = 1'b0;
    x_data    = '0;
    y_ready   = 1'b0;
    data_out  = '0;
    for (int i = 0; i < N_COEFF; i++) bankModel[i] = '0;

    // Values while reset is held.
    #3;
    checkOutput("rst x_ready", 32'(x_ready), 32'd1);
    checkOutput("rst data_in", 32'(data_in), 32'd0);
    checkOutput("rst coeff_in", 32'(coeff_in), 32'd0);
    checkOutput("rst y_valid", 32'(y_valid), 32'd0);
    checkOutput("rst y_data", 32'(y_data), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    $display("[TB] reset released");

    // Bank reads as zero after reset.
    applyStimulus(WL'($urandom), OUT'($urandom), 0, 1'b0, 1'b0, 0, '0);

    // Basic stream with the known bank and result, then 10 cycles of backpressure.
    writeCoeff(0, 4'b0010);
    writeCoeff(1, 4'b0011);
    writeCoeff(2, 4'b0001);
    writeCoeff(3, 4'b0000);
    applyStimulus(4'b0100, 13'h0A5, 10, 1'b0, 1'b0, 0, '0);

    // Busy-time write is ignored now and later.
    applyStimulus(WL'($urandom), OUT'($urandom), 1, 1'b1, 1'b0, 0, '0);
    applyStimulus(WL'($urandom), OUT'($urandom), 0, 1'b0, 1'b0, 0, '0);

    // Write in the accept cycle is used by that very stream.
    applyStimulus(WL'($urandom), OUT'($urandom), 2, 1'b0, 1'b1, 2, 4'b1001);

    // Randomized traffic.
    for (int t = 0; t < 8; t++) begin
      int nWr;
      nWr = $urandom_range(0, 2);
      for (int w = 0; w < nWr; w++) writeCoeff($urandom_range(0, N_COEFF-1), CL'($urandom));
      applyStimulus(WL'($urandom), OUT'($urandom), $urandom_range(0, 3), 1'($urandom),
                    1'($urandom), $urandom_range(0, N_COEFF-1), CL'($urandom));
    end

    // Reset in the middle of a stream.
    @(negedge clock);
    x_valid = 1'b1;
    x_data  = 4'b0101;
    @(posedge clock);
    #1;
    x_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("pre-reset data_in", 32'(data_in), 32'd5);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("async rst data_in", 32'(data_in), 32'd0);
    checkOutput("async rst coeff_in", 32'(coeff_in), 32'd0);
    checkOutput("async rst busy", 32'(busy), 32'd0);
    checkOutput("async rst x_ready", 32'(x_ready), 32'd1);
    for (int i = 0; i < N_COEFF; i++) bankModel[i] = '0;
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      data_out = OUT'($urandom);
      @(posedge clock);
      @(negedge clock);
      checkOutput("post-reset y_valid", 32'(y_valid), 32'd0);
      checkOutput("post-reset busy", 32'(busy), 32'd0);
    end
    applyStimulus(WL'($urandom), OUT'($urandom), 1, 1'b0, 1'b0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
